// File: rtl/maze_pkg.sv
// Shared definitions for the maze explorer: coordinate widths, move encoding,
// FSM state enum and the {x, y} memory address payload.
package maze_pkg;

    localparam int unsigned COORD_W  = 4;
    localparam int unsigned LOC_W    = 2 * COORD_W;
    localparam int unsigned DIR_BITS = 2;

    // Move encoding: E = y+1, S = x+1, W = y-1, N = x-1
    localparam logic [DIR_BITS-1:0] DIR_E = 2'd0;
    localparam logic [DIR_BITS-1:0] DIR_S = 2'd1;
    localparam logic [DIR_BITS-1:0] DIR_W = 2'd2;
    localparam logic [DIR_BITS-1:0] DIR_N = 2'd3;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INIT,
        ST_PICK,
        ST_READ,
        ST_EVAL,
        ST_MOVE,
        ST_BACK,
        ST_DONE,
        ST_FAIL
    } state_e;

    // Memory address payload, x in the upper half
    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } loc_t;

    function automatic loc_t pack_loc(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
        loc_t l;
        l.x = x;
        l.y = y;
        return l;
    endfunction

endpackage

// File: rtl/move_stack.sv
// LIFO of 2-bit moves for the depth-first search, with an extra indexed read
// port so the finished path can be streamed bottom-to-top.
// Ports: clr_i/push_i/pop_i control, din_i push data, top_o top entry,
//        full_o/empty_o flags, sp_o entry count, rd_idx_i/rd_data_o random read.
module move_stack #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned SP_W  = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr_i,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [1:0]      din_i,
    output logic [1:0]      top_o,
    output logic            full_o,
    output logic            empty_o,
    output logic [SP_W-1:0] sp_o,
    input  logic [SP_W-1:0] rd_idx_i,
    output logic [1:0]      rd_data_o
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [1:0]      mem_q [DEPTH];
    logic [SP_W-1:0] sp_q;

    assign full_o    = (sp_q == SP_W'(DEPTH));
    assign empty_o   = (sp_q == '0);
    assign sp_o      = sp_q;
    assign top_o     = mem_q[IDX_W'(sp_q - SP_W'(1))];
    assign rd_data_o = mem_q[IDX_W'(rd_idx_i)];

    // Stack pointer; clear wins, pushes/pops beyond limits are dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q <= '0;
        end else if (clr_i) begin
            sp_q <= '0;
        end else if (push_i && !full_o) begin
            sp_q <= sp_q + SP_W'(1);
        end else if (pop_i && !empty_o) begin
            sp_q <= sp_q - SP_W'(1);
        end
    end

    // Entry storage needs no reset: only slots below sp are ever read
    always_ff @(posedge clk) begin
        if (push_i && !full_o && !clr_i) begin
            mem_q[IDX_W'(sp_q)] <= din_i;
        end
    end

endmodule

// File: rtl/maze_explorer.sv
// Depth-first maze solver owning the 16x16 maze memory port. Walks from START
// to GOAL marking visited cells, backtracks via move_stack, then streams the
// solution path one move per cycle.
// Ports: start pulse; mem_dout read data (1-cycle latency); mem_loc/mem_rd/
//        mem_wr/mem_din memory control; busy/done/fail status; path_len and
//        path_valid/path_dir/path_last solution stream.
module maze_explorer
    import maze_pkg::*;
#(
    parameter int unsigned START_X     = 0,
    parameter int unsigned START_Y     = 0,
    parameter int unsigned GOAL_X      = 15,
    parameter int unsigned GOAL_Y      = 15,
    parameter int unsigned STACK_DEPTH = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mem_dout,
    output logic [LOC_W-1:0] mem_loc,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             mem_din,
    output logic             busy,
    output logic             done,
    output logic             fail,
    output logic [8:0]       path_len,
    output logic             path_valid,
    output logic [1:0]       path_dir,
    output logic             path_last
);

    localparam int unsigned SP_W = $clog2(STACK_DEPTH + 1);
    localparam logic [COORD_W-1:0] CMAX = '1;
    localparam logic [COORD_W-1:0] SX   = COORD_W'(START_X);
    localparam logic [COORD_W-1:0] SY   = COORD_W'(START_Y);
    localparam logic [COORD_W-1:0] GX   = COORD_W'(GOAL_X);
    localparam logic [COORD_W-1:0] GY   = COORD_W'(GOAL_Y);

    state_e             state_q;
    logic [COORD_W-1:0] pos_x_q, pos_y_q;
    logic [2:0]         dir_q;
    loc_t               mem_loc_q;
    logic               mem_rd_q, mem_wr_q;
    logic               busy_q, done_q, fail_q;
    logic [8:0]         path_len_q;
    logic               path_valid_q, path_last_q;
    logic [1:0]         path_dir_q;
    logic [SP_W-1:0]    str_idx_q;
    logic               str_act_q;

    logic [COORD_W-1:0] nb_x, nb_y, bk_x, bk_y;
    logic               nb_off;
    logic [1:0]         stk_top, stk_rd;
    logic               stk_full, stk_empty;
    logic [SP_W-1:0]    sp;

    // Neighbour of pos in direction dir; off-map flagged before any arithmetic wraps
    always_comb begin
        nb_x   = pos_x_q;
        nb_y   = pos_y_q;
        nb_off = 1'b0;
        case (dir_q[1:0])
            DIR_E:   begin nb_off = (pos_y_q == CMAX); nb_y = pos_y_q + COORD_W'(1); end
            DIR_S:   begin nb_off = (pos_x_q == CMAX); nb_x = pos_x_q + COORD_W'(1); end
            DIR_W:   begin nb_off = (pos_y_q == '0);   nb_y = pos_y_q - COORD_W'(1); end
            default: begin nb_off = (pos_x_q == '0);   nb_x = pos_x_q - COORD_W'(1); end
        endcase
    end

    // Cell we came from: undo the move on top of the stack
    always_comb begin
        bk_x = pos_x_q;
        bk_y = pos_y_q;
        case (stk_top)
            DIR_E:   bk_y = pos_y_q - COORD_W'(1);
            DIR_S:   bk_x = pos_x_q - COORD_W'(1);
            DIR_W:   bk_y = pos_y_q + COORD_W'(1);
            default: bk_x = pos_x_q + COORD_W'(1);
        endcase
    end

    move_stack #(.DEPTH(STACK_DEPTH), .SP_W(SP_W)) u_stack (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (state_q == ST_INIT),
        .push_i   (state_q == ST_MOVE),
        .pop_i    (state_q == ST_BACK),
        .din_i    (dir_q[1:0]),
        .top_o    (stk_top),
        .full_o   (stk_full),
        .empty_o  (stk_empty),
        .sp_o     (sp),
        .rd_idx_i (str_idx_q),
        .rd_data_o(stk_rd)
    );

    // Search FSM with registered memory, status and stream outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            pos_x_q      <= '0;
            pos_y_q      <= '0;
            dir_q        <= '0;
            mem_loc_q    <= '0;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fail_q       <= 1'b0;
            path_len_q   <= '0;
            path_valid_q <= 1'b0;
            path_dir_q   <= '0;
            path_last_q  <= 1'b0;
            str_idx_q    <= '0;
            str_act_q    <= 1'b0;
        end else begin
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            path_valid_q <= 1'b0;
            path_last_q  <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE, ST_FAIL: begin
                    if (start) begin
                        // Mark START visited during INIT
                        state_q    <= ST_INIT;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        fail_q     <= 1'b0;
                        path_len_q <= '0;
                        str_act_q  <= 1'b0;
                        mem_wr_q   <= 1'b1;
                        mem_loc_q  <= pack_loc(SX, SY);
                    end else if (state_q == ST_DONE && str_act_q) begin
                        path_valid_q <= 1'b1;
                        path_dir_q   <= stk_rd;
                        path_last_q  <= (str_idx_q == sp - SP_W'(1));
                        str_idx_q    <= str_idx_q + SP_W'(1);
                        if (str_idx_q == sp - SP_W'(1)) begin
                            str_act_q <= 1'b0;
                        end
                    end
                end
                ST_INIT: begin
                    pos_x_q <= SX;
                    pos_y_q <= SY;
                    dir_q   <= '0;
                    if (SX == GX && SY == GY) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= ST_PICK;
                    end
                end
                ST_PICK: begin
                    if (dir_q[2]) begin
                        state_q <= ST_BACK;
                    end else if (nb_off) begin
                        dir_q <= dir_q + 3'd1;
                    end else begin
                        state_q   <= ST_READ;
                        mem_rd_q  <= 1'b1;
                        mem_loc_q <= pack_loc(nb_x, nb_y);
                    end
                end
                ST_READ: begin
                    state_q <= ST_EVAL;
                end
                ST_EVAL: begin
                    if (mem_dout) begin
                        dir_q   <= dir_q + 3'd1;
                        state_q <= ST_PICK;
                    end else begin
                        // mem_loc still holds the neighbour address
                        mem_wr_q <= 1'b1;
                        state_q  <= ST_MOVE;
                    end
                end
                ST_MOVE: begin
                    if (stk_full) begin
                        state_q <= ST_FAIL;
                        busy_q  <= 1'b0;
                        fail_q  <= 1'b1;
                    end else begin
                        pos_x_q <= nb_x;
                        pos_y_q <= nb_y;
                        dir_q   <= '0;
                        if (nb_x == GX && nb_y == GY) begin
                            state_q    <= ST_DONE;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                            path_len_q <= 9'(sp + SP_W'(1));
                            str_idx_q  <= '0;
                            str_act_q  <= 1'b1;
                        end else begin
                            state_q <= ST_PICK;
                        end
                    end
                end
                ST_BACK: begin
                    if (stk_empty) begin
                        state_q <= ST_FAIL;
                        busy_q  <= 1'b0;
                        fail_q  <= 1'b1;
                    end else begin
                        pos_x_q <= bk_x;
                        pos_y_q <= bk_y;
                        dir_q   <= {1'b0, stk_top} + 3'd1;
                        state_q <= ST_PICK;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mem_loc    = mem_loc_q;
    assign mem_rd     = mem_rd_q;
    assign mem_wr     = mem_wr_q;
    assign mem_din    = mem_wr_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign fail       = fail_q;
    assign path_len   = path_len_q;
    assign path_valid = path_valid_q;
    assign path_dir   = path_dir_q;
    assign path_last  = path_last_q;

endmodule

// File: tb/tb_maze_explorer.sv
// Self-checking bench for maze_explorer: directed maps from a table, random
// maps against a behavioural DFS reference, plus reset/restart and START==GOAL.
module tb_maze_explorer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       mem_dout = 1'b0;
    logic [7:0] mem_loc;
    logic       mem_rd, mem_wr, mem_din, busy, done, fail;
    logic [8:0] path_len;
    logic       path_valid, path_last;
    logic [1:0] path_dir;

    logic       start2 = 1'b0;
    logic       mem2_dout = 1'b0;
    logic [7:0] mem2_loc;
    logic       mem2_rd, mem2_wr, mem2_din, busy2, done2, fail2;
    logic [8:0] path_len2;
    logic       path_valid2, path_last2;
    logic [1:0] path_dir2;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    maze_explorer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mem_dout(mem_dout),
        .mem_loc(mem_loc), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_din(mem_din),
        .busy(busy), .done(done), .fail(fail), .path_len(path_len),
        .path_valid(path_valid), .path_dir(path_dir), .path_last(path_last)
    );

    maze_explorer #(.START_X(0), .START_Y(0), .GOAL_X(0), .GOAL_Y(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .mem_dout(mem2_dout),
        .mem_loc(mem2_loc), .mem_rd(mem2_rd), .mem_wr(mem2_wr), .mem_din(mem2_din),
        .busy(busy2), .done(done2), .fail(fail2), .path_len(path_len2),
        .path_valid(path_valid2), .path_dir(path_dir2), .path_last(path_last2)
    );

    // Behavioural maze memories, 1-cycle read latency
    bit   init_map [256];
    logic mem [256];
    logic mem2 [256];
    bit   load_req = 1'b0;

    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_map[i];
        end else begin
            if (mem_rd) mem_dout <= mem[mem_loc];
            if (mem_wr) mem[mem_loc] <= mem_din;
        end
    end

    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < 256; i++) mem2[i] <= 1'b0;
        end else begin
            if (mem2_rd) mem2_dout <= mem2[mem2_loc];
            if (mem2_wr) mem2[mem2_loc] <= mem2_din;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Memory-port protocol monitor
    always @(negedge clk) begin
        if (rst_n && !load_req) begin
            if (mem_rd && mem_wr) begin
                miscompares++;
                $display("FAIL proto_rd_wr: got rd=1 wr=1, expected exclusive");
            end
            if (mem_wr && mem_din !== 1'b1) begin
                miscompares++;
                $display("FAIL proto_din: got %0d, expected 1", mem_din);
            end
            if (mem_wr && mem[mem_loc] === 1'b1) begin
                miscompares++;
                $display("FAIL proto_wr_blocked: write to occupied cell %0h", mem_loc);
            end
        end
    end

    // Stream collectors
    int got_dirs[$];
    int last_cnt, last_idx, pv2_cnt;
    always @(negedge clk) begin
        if (rst_n && path_valid) begin
            if (path_last) begin
                last_cnt++;
                last_idx = got_dirs.size();
            end
            got_dirs.push_back(int'(path_dir));
        end
        if (rst_n && path_valid2) pv2_cnt++;
    end

    // Reference DFS from (0,0) to (15,15) on init_map
    int exp_path[$];
    bit exp_ok;

    function automatic int ddx(input int d);
        return (d == 1) ? 1 : (d == 3) ? -1 : 0;
    endfunction
    function automatic int ddy(input int d);
        return (d == 0) ? 1 : (d == 2) ? -1 : 0;
    endfunction

    task automatic ref_solve();
        bit vis [256];
        int px, py, d, dd, nx, ny;
        bit moved;
        for (int i = 0; i < 256; i++) vis[i] = init_map[i];
        exp_path.delete();
        exp_ok = 1'b0;
        px = 0; py = 0; d = 0;
        vis[0] = 1'b1;
        for (int it = 0; it < 100000; it++) begin
            if (px == 15 && py == 15) begin
                exp_ok = 1'b1;
                break;
            end
            moved = 1'b0;
            dd = d;
            while (dd < 4 && !moved) begin
                nx = px + ddx(dd);
                ny = py + ddy(dd);
                if (nx >= 0 && nx < 16 && ny >= 0 && ny < 16 && !vis[nx*16+ny]) begin
                    vis[nx*16+ny] = 1'b1;
                    exp_path.push_back(dd);
                    px = nx; py = ny; d = 0;
                    moved = 1'b1;
                end else begin
                    dd++;
                end
            end
            if (!moved) begin
                if (exp_path.size() == 0) break;
                dd = exp_path.pop_back();
                px -= ddx(dd);
                py -= ddy(dd);
                d = dd + 1;
            end
        end
    endtask

    task automatic load_map();
        @(negedge clk) load_req = 1'b1;
        @(negedge clk) load_req = 1'b0;
    endtask

    // 0 empty, 1 column y=1 walled except x=15, 2 start boxed in, 3 dead-end corridor
    task automatic build_map(input int kind);
        for (int i = 0; i < 256; i++) init_map[i] = 1'b0;
        case (kind)
            1: for (int x = 0; x < 15; x++) init_map[x*16+1] = 1'b1;
            2: begin init_map[1] = 1'b1; init_map[16] = 1'b1; end
            3: begin
                init_map[5] = 1'b1;
                for (int y = 1; y <= 4; y++) init_map[16+y] = 1'b1;
            end
            default: ;
        endcase
    endtask

    task automatic pulse_start(output int cycles);
        got_dirs.delete();
        last_cnt = 0;
        last_idx = -1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cycles = 0;
    endtask

    task automatic wait_end(input string tag, inout int cycles);
        while (!(done || fail) && cycles < 20000) begin
            @(negedge clk);
            cycles++;
        end
        if (cycles >= 20000) chk({tag, "_timeout"}, cycles, 0);
        repeat (int'(path_len) + 4) @(negedge clk);
    endtask

    task automatic check_vs_model(input string tag);
        int px, py, mism;
        bit seen [256];
        ref_solve();
        chk({tag, "_done"}, int'(done), int'(exp_ok));
        chk({tag, "_fail"}, int'(fail), int'(!exp_ok));
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_len"}, int'(path_len), exp_ok ? exp_path.size() : 0);
        chk({tag, "_nvalid"}, got_dirs.size(), exp_ok ? exp_path.size() : 0);
        chk({tag, "_nlast"}, last_cnt, (exp_ok && exp_path.size() > 0) ? 1 : 0);
        if (exp_ok && exp_path.size() > 0) begin
            chk({tag, "_lastidx"}, last_idx, exp_path.size() - 1);
            mism = -1;
            for (int i = 0; i < exp_path.size() && i < got_dirs.size(); i++)
                if (mism < 0 && got_dirs[i] != exp_path[i]) mism = i;
            chk({tag, "_dirs_first_diff"}, mism, -1);
            // Streamed path must be a simple walk ending on GOAL
            for (int i = 0; i < 256; i++) seen[i] = 1'b0;
            px = 0; py = 0; seen[0] = 1'b1; mism = 0;
            foreach (got_dirs[i]) begin
                px += ddx(got_dirs[i]);
                py += ddy(got_dirs[i]);
                if (px < 0 || px > 15 || py < 0 || py > 15) mism = 1;
                else if (seen[px*16+py] || init_map[px*16+py]) mism = 1;
                else seen[px*16+py] = 1'b1;
            end
            chk({tag, "_walk_bad"}, mism, 0);
            chk({tag, "_walk_end"}, px*16+py, 255);
        end
    endtask

    typedef struct {
        int kind;
        bit exp_done;
        int exp_len;
        int exp_d0;
        int exp_d15;
    } vec_t;

    initial begin
        vec_t tbl [4];
        int   cyc;
        tbl[0] = '{0, 1'b1, 30, 0, 1};
        tbl[1] = '{1, 1'b1, 30, 1, 0};
        tbl[2] = '{2, 1'b0, 0, 0, 0};
        tbl[3] = '{3, 1'b1, 30, 1, 0};

        repeat (2) @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_outs", int'({done, fail, mem_rd, mem_wr, path_valid, path_last}), 0);
        chk("reset_loc", int'(mem_loc), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed maps
        for (int v = 0; v < 4; v++) begin
            string tag;
            tag = $sformatf("map%0d", tbl[v].kind);
            build_map(tbl[v].kind);
            load_map();
            pulse_start(cyc);
            chk({tag, "_busy_run"}, int'(busy), 1);
            wait_end(tag, cyc);
            chk({tag, "_tbl_done"}, int'(done), int'(tbl[v].exp_done));
            chk({tag, "_tbl_len"}, int'(path_len), tbl[v].exp_len);
            if (tbl[v].exp_done) begin
                chk({tag, "_tbl_d0"}, got_dirs.size() > 0 ? got_dirs[0] : -1, tbl[v].exp_d0);
                chk({tag, "_tbl_d15"}, got_dirs.size() > 15 ? got_dirs[15] : -1, tbl[v].exp_d15);
            end else begin
                chk({tag, "_fail_latency_le12"}, int'(cyc <= 12), 1);
            end
            check_vs_model(tag);
        end

        // Random maps
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 256; i++) init_map[i] = ($urandom_range(0, 99) < 33);
            init_map[0] = 1'b0;
            init_map[255] = 1'b0;
            load_map();
            pulse_start(cyc);
            wait_end($sformatf("rnd%0d", r), cyc);
            check_vs_model($sformatf("rnd%0d", r));
        end

        // Reset mid-run, then a fresh run with a stray start while busy
        build_map(0);
        load_map();
        pulse_start(cyc);
        repeat (40) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_outs", int'({done, fail, mem_rd, mem_wr, mem_din, path_valid, path_last}), 0);
        chk("midrst_loc", int'(mem_loc), 0);
        @(negedge clk) rst_n = 1'b1;
        load_map();
        pulse_start(cyc);
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        cyc += 6;
        wait_end("restart", cyc);
        check_vs_model("restart");

        // START == GOAL instance
        pv2_cnt = 0;
        @(negedge clk) start2 = 1'b1;
        @(negedge clk) start2 = 1'b0;
        chk("sg_init_done", int'(done2), 0);
        chk("sg_init_busy", int'(busy2), 1);
        @(negedge clk);
        chk("sg_done", int'(done2), 1);
        chk("sg_len", int'(path_len2), 0);
        repeat (10) @(negedge clk);
        chk("sg_no_valid", pv2_cnt, 0);
        chk("sg_fail", int'(fail2), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
